// File: rtl/counter4bit_pkg.sv
// counter4bit_pkg: code table, FSM states and successor helper for the 12-step sequence counter.
package counter4bit_pkg;

    localparam int SEQ_LEN = 12;

    localparam logic [3:0] SEQ [SEQ_LEN] = '{
        4'b0000, 4'b1110, 4'b1101, 4'b1100, 4'b1000, 4'b0001,
        4'b0011, 4'b0111, 4'b1111, 4'b1010, 4'b0101, 4'b1001
    };

    typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

    // Unused codes map to themselves so they never look like a legal step.
    function automatic logic [3:0] succ(input logic [3:0] code);
        succ = code;
        for (int i = 0; i < SEQ_LEN; i++)
            if (SEQ[i] == code) succ = SEQ[(i == SEQ_LEN - 1) ? 0 : i + 1];
    endfunction

endpackage

// File: rtl/counter4bit_seq_monitor_if.sv
// counter4bit_seq_monitor_if: present-state input and status outputs of the sequence monitor.
interface counter4bit_seq_monitor_if #(
    parameter int LAP_W = 8,
    parameter int ERR_W = 4
);
    logic [3:0]       present;
    logic             clear;
    logic [3:0]       index;
    logic             valid;
    logic             seq_error;
    logic             illegal;
    logic             error_sticky;
    logic [ERR_W-1:0] err_count;
    logic [LAP_W-1:0] lap_count;
    logic             lap_pulse;

    modport master (
        output present, clear,
        input  index, valid, seq_error, illegal, error_sticky, err_count, lap_count, lap_pulse
    );

    modport slave (
        input  present, clear,
        output index, valid, seq_error, illegal, error_sticky, err_count, lap_count, lap_pulse
    );
endinterface

// File: rtl/counter4bit_decode.sv
// counter4bit_decode: maps a 4-bit code to its ordinal in the sequence and flags unused codes.
module counter4bit_decode
    import counter4bit_pkg::*;
(
    input  logic [3:0] present,
    output logic [3:0] index,
    output logic       legal
);
    always_comb begin
        index = '0;
        legal = 1'b0;
        for (int i = 0; i < SEQ_LEN; i++)
            if (SEQ[i] == present) begin
                index = 4'(i);
                legal = 1'b1;
            end
    end
endmodule

// File: rtl/counter4bit_seq_monitor.sv
// counter4bit_seq_monitor: tracks the sequence counter's present state, flags bad steps, counts laps and errors.
module counter4bit_seq_monitor
    import counter4bit_pkg::*;
#(
    parameter int LAP_W  = 8,
    parameter int ERR_W  = 4,
    parameter bit RESYNC = 1'b1
) (
    input logic clock,
    input logic resetn,
    counter4bit_seq_monitor_if.slave bus
);
    state_t           state;
    logic [3:0]       prev;
    logic [3:0]       dec_index;
    logic             legal;
    logic             is_succ;
    logic             err_ev;
    logic [LAP_W-1:0] laps;
    logic [ERR_W-1:0] errs;

    counter4bit_decode u_decode (.present(bus.present), .index(dec_index), .legal(legal));

    // FAULT deliberately stops error counting, so only SYNC and TRACK raise events.
    always_comb begin
        is_succ = bus.present == succ(prev);
        err_ev  = !bus.clear && ((state == SYNC && !legal) ||
                  (state == TRACK && bus.present != prev && !is_succ));
    end

    assign bus.lap_count = laps;
    assign bus.err_count = errs;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state            <= SYNC;
            prev             <= '0;
            bus.index        <= '0;
            bus.valid        <= 1'b0;
            bus.seq_error    <= 1'b0;
            bus.illegal      <= 1'b0;
            bus.lap_pulse    <= 1'b0;
            bus.error_sticky <= 1'b0;
            laps             <= '0;
            errs             <= '0;
        end else begin
            bus.seq_error <= 1'b0;
            bus.illegal   <= 1'b0;
            bus.lap_pulse <= 1'b0;
            if (bus.clear) begin
                state            <= SYNC;
                bus.valid        <= 1'b0;
                bus.error_sticky <= 1'b0;
                laps             <= '0;
                errs             <= '0;
            end else begin
                case (state)
                    SYNC: begin
                        if (legal) begin
                            prev      <= bus.present;
                            bus.index <= dec_index;
                            bus.valid <= 1'b1;
                            state     <= TRACK;
                        end else begin
                            bus.illegal <= 1'b1;
                        end
                    end
                    TRACK: begin
                        if (bus.present == prev) begin
                        end else if (is_succ) begin
                            prev      <= bus.present;
                            bus.index <= dec_index;
                            if (prev == SEQ[SEQ_LEN-1]) begin
                                laps          <= laps + 1'b1;
                                bus.lap_pulse <= 1'b1;
                            end
                        end else if (legal) begin
                            bus.seq_error <= 1'b1;
                            if (RESYNC) begin
                                prev      <= bus.present;
                                bus.index <= dec_index;
                            end else begin
                                bus.valid <= 1'b0;
                                state     <= FAULT;
                            end
                        end else begin
                            bus.illegal <= 1'b1;
                            bus.valid   <= 1'b0;
                            state       <= FAULT;
                        end
                    end
                    default: ;
                endcase
                if (err_ev) begin
                    bus.error_sticky <= 1'b1;
                    if (~&errs) errs <= errs + 1'b1;
                end
            end
        end
    end
endmodule
